// File: rtl/dev_sched_pkg.sv
// Shared types and constants for the two-device scheduler.
//   NDEV          number of worker devices behind the scheduler
//   slot_state_e  per-device lifecycle state
//   idw()         index width for a population of n items (min 1 bit)
package dev_sched_pkg;

  localparam int unsigned NDEV = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } slot_state_e;

  // $clog2 wrapper that never returns 0, so single-item indices stay legal.
  function automatic int unsigned idw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dev_sched_slot.sv
// One device slot: lifecycle FSM, watchdog counter and owner register.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   dispatch          launch a job on this slot (only honoured while IDLE)
//   dispatch_owner    requester index that owns the launched job
//   done              device done pulse
//   active_c          slot is ACTIVE
//   done_evt_c        job completes on this edge (done while ACTIVE)
//   timeout_evt_c     watchdog expires on this edge (loses to done)
//   spur_c            done seen while IDLE
//   owner             registered owner index, 0 while IDLE
module dev_slot
  import dev_sched_pkg::*;
#(
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           dispatch,
  input  logic [IDW-1:0] dispatch_owner,
  input  logic           done,
  output logic           active_c,
  output logic           done_evt_c,
  output logic           timeout_evt_c,
  output logic           spur_c,
  output logic [IDW-1:0] owner
);

  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  slot_state_e    state;
  slot_state_e    state_next;
  logic [WDW-1:0] wd;
  logic [WDW-1:0] wd_next;
  logic [IDW-1:0] owner_next;
  logic           wd_at_limit;

  assign wd_at_limit = (wd == WDW'(TIMEOUT));

  // State, watchdog and owner registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wd    <= '0;
      owner <= '0;
    end else begin
      state <= state_next;
      wd    <= wd_next;
      owner <= owner_next;
    end
  end

  // Next-state: launch from IDLE; leave ACTIVE on done or watchdog expiry.
  always_comb begin
    state_next = state;
    wd_next    = wd;
    owner_next = owner;
    case (state)
      IDLE: begin
        if (dispatch) begin
          state_next = ACTIVE;
          wd_next    = '0;
          owner_next = dispatch_owner;
        end
      end
      ACTIVE: begin
        if (done || wd_at_limit) begin
          state_next = IDLE;
          wd_next    = '0;
          owner_next = '0;
        end else begin
          // Never exceeds TIMEOUT: reaching it forces the exit above.
          wd_next = wd + WDW'(1);
        end
      end
    endcase
  end

  // Event outputs decoded from the current state and the done input.
  always_comb begin
    active_c      = (state == ACTIVE);
    done_evt_c    = active_c && done;
    timeout_evt_c = active_c && !done && wd_at_limit;
    spur_c        = !active_c && done;
  end

endmodule

// File: rtl/dev_sched.sv
// Round-robin scheduler sharing NDEV worker devices among NREQ requesters.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   req_i          level request per requester, held until ack
//   ack_o          pulse: request accepted and dispatched
//   cpl_o          pulse: owner's job completed
//   err_o          pulse: owner's job aborted by the watchdog
//   dev_req_o      launch pulse per device
//   dev_busy_i     device busy level
//   dev_done_i     device done pulse
//   dev_owner_o    packed owner index per device, 0 when idle
//   spur_o         sticky: done seen on an idle device
module dev_sched
  import dev_sched_pkg::*;
#(
  parameter  int unsigned NREQ    = 4,
  parameter  int unsigned TIMEOUT = 32,
  localparam int unsigned IDW     = idw(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_i,
  output logic [NREQ-1:0]     ack_o,
  output logic [NREQ-1:0]     cpl_o,
  output logic [NREQ-1:0]     err_o,
  output logic [NDEV-1:0]     dev_req_o,
  input  logic [NDEV-1:0]     dev_busy_i,
  input  logic [NDEV-1:0]     dev_done_i,
  output logic [NDEV*IDW-1:0] dev_owner_o,
  output logic                spur_o
);

  localparam int unsigned DIW = idw(NDEV);

  logic [NDEV-1:0] slot_active;
  logic [NDEV-1:0] slot_done;
  logic [NDEV-1:0] slot_timeout;
  logic [NDEV-1:0] slot_spur;
  logic [IDW-1:0]  slot_owner [NDEV];

  logic [IDW-1:0]  rr;
  logic [IDW-1:0]  rr_next_c;
  logic [NREQ-1:0] owned_c;
  logic [NREQ-1:0] cand_c;
  logic            dev_ok_c;
  logic [DIW-1:0]  dev_idx_c;
  logic            found_c;
  logic            grant_c;
  logic [IDW-1:0]  grant_idx_c;
  logic [NDEV-1:0] dispatch_c;
  logic [NREQ-1:0] ack_next_c;
  logic [NREQ-1:0] cpl_next_c;
  logic [NREQ-1:0] err_next_c;

  for (genvar d = 0; d < NDEV; d++) begin : g_slot
    dev_slot #(
      .IDW     (IDW),
      .TIMEOUT (TIMEOUT)
    ) u_slot (
      .clk            (clk),
      .rst_n          (rst_n),
      .dispatch       (dispatch_c[d]),
      .dispatch_owner (grant_idx_c),
      .done           (dev_done_i[d]),
      .active_c       (slot_active[d]),
      .done_evt_c     (slot_done[d]),
      .timeout_evt_c  (slot_timeout[d]),
      .spur_c         (slot_spur[d]),
      .owner          (slot_owner[d])
    );
    assign dev_owner_o[d*IDW +: IDW] = slot_owner[d];
  end

  // Arbiter: mask requesters that already own a device, pick the lowest
  // eligible device, and grant the first candidate at or after rr.
  always_comb begin
    int pos;
    owned_c     = '0;
    dev_ok_c    = 1'b0;
    dev_idx_c   = '0;
    found_c     = 1'b0;
    grant_idx_c = '0;
    pos         = 0;
    for (int d = 0; d < int'(NDEV); d++) begin
      if (slot_active[d]) owned_c[slot_owner[d]] = 1'b1;
    end
    cand_c = req_i & ~owned_c;
    // Descending scans: the last hit is the lowest index / nearest to rr.
    for (int d = int'(NDEV) - 1; d >= 0; d--) begin
      if (!slot_active[d] && !dev_busy_i[d]) begin
        dev_ok_c  = 1'b1;
        dev_idx_c = DIW'(d);
      end
    end
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      pos = (int'(rr) + i) % int'(NREQ);
      if (cand_c[IDW'(pos)]) begin
        found_c     = 1'b1;
        grant_idx_c = IDW'(pos);
      end
    end
    grant_c = found_c && dev_ok_c;
  end

  // Next values for the pulse outputs and the round-robin pointer.
  always_comb begin
    ack_next_c = '0;
    cpl_next_c = '0;
    err_next_c = '0;
    dispatch_c = '0;
    rr_next_c  = rr;
    if (grant_c) begin
      ack_next_c[grant_idx_c] = 1'b1;
      rr_next_c = (grant_idx_c == IDW'(NREQ - 1)) ? '0 : grant_idx_c + IDW'(1);
      for (int d = 0; d < int'(NDEV); d++) begin
        dispatch_c[d] = (dev_idx_c == DIW'(d));
      end
    end
    // Owners of concurrently finishing devices are distinct by masking.
    for (int d = 0; d < int'(NDEV); d++) begin
      if (slot_done[d])    cpl_next_c[slot_owner[d]] = 1'b1;
      if (slot_timeout[d]) err_next_c[slot_owner[d]] = 1'b1;
    end
  end

  // Registered outputs, pointer and sticky spurious-done flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr        <= '0;
      ack_o     <= '0;
      cpl_o     <= '0;
      err_o     <= '0;
      dev_req_o <= '0;
      spur_o    <= 1'b0;
    end else begin
      rr        <= rr_next_c;
      ack_o     <= ack_next_c;
      cpl_o     <= cpl_next_c;
      err_o     <= err_next_c;
      dev_req_o <= dispatch_c;
      spur_o    <= spur_o | (|slot_spur);
    end
  end

endmodule

// File: tb/tb_dev_sched.sv
// Self-checking bench for dev_sched (NREQ=4, TIMEOUT=8): directed vector
// table, hand-written corner sequences, and randomized traffic compared
// against a job-level reference model every cycle.
module tb_dev_sched;

  localparam int unsigned NREQ = 4;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_i;
  logic [3:0] ack_o;
  logic [3:0] cpl_o;
  logic [3:0] err_o;
  logic [1:0] dev_req_o;
  logic [1:0] dev_busy_i;
  logic [1:0] dev_done_i;
  logic [3:0] dev_owner_o;
  logic       spur_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dev_sched #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .ack_o       (ack_o),
    .cpl_o       (cpl_o),
    .err_o       (err_o),
    .dev_req_o   (dev_req_o),
    .dev_busy_i  (dev_busy_i),
    .dev_done_i  (dev_done_i),
    .dev_owner_o (dev_owner_o),
    .spur_o      (spur_o)
  );

  // ---------------- reference model: jobs on two devices ----------------
  bit         m_act [2];
  int         m_own [2];
  int         m_age [2];
  int         m_rr;
  bit         m_spur;
  logic [3:0] e_ack, e_cpl, e_err;
  logic [1:0] e_dreq;

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_own[d] = 0; m_age[d] = 0;
    end
    m_rr = 0; m_spur = 0;
    e_ack = '0; e_cpl = '0; e_err = '0; e_dreq = '0;
  endfunction

  function automatic void model_edge(input logic [3:0] req, input logic [1:0] busy,
                                     input logic [1:0] done);
    bit fin [2];
    int dv, g, r;
    bit owned;
    e_ack = '0; e_cpl = '0; e_err = '0; e_dreq = '0;
    for (int d = 0; d < 2; d++) begin
      fin[d] = 0;
      if (m_act[d]) begin
        if (done[d]) begin
          e_cpl = e_cpl | (4'b0001 << m_own[d]); fin[d] = 1;
        end else if (m_age[d] >= TO) begin
          e_err = e_err | (4'b0001 << m_own[d]); fin[d] = 1;
        end
      end else if (done[d]) begin
        m_spur = 1;
      end
    end
    dv = -1;
    if (!m_act[1] && !busy[1]) dv = 1;
    if (!m_act[0] && !busy[0]) dv = 0;
    g = -1;
    if (dv >= 0) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        r = (m_rr + i) % int'(NREQ);
        owned = (m_act[0] && m_own[0] == r) || (m_act[1] && m_own[1] == r);
        if (g < 0 && req[2'(r)] && !owned) g = r;
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (fin[d]) begin
        m_act[d] = 0; m_own[d] = 0; m_age[d] = 0;
      end else if (m_act[d]) begin
        m_age[d] = (m_age[d] < TO) ? m_age[d] + 1 : TO;
      end
    end
    if (g >= 0) begin
      e_ack = 4'b0001 << g;
      e_dreq = 2'b01 << dv;
      m_act[dv] = 1; m_own[dv] = g; m_age[dv] = 0;
      m_rr = (g + 1) % int'(NREQ);
    end
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return 32'({ack_o, dev_req_o, cpl_o, err_o, dev_owner_o, spur_o});
  endfunction

  function automatic logic [31:0] model_vec();
    return 32'({e_ack, e_dreq, e_cpl, e_err, 2'(m_own[1]), 2'(m_own[0]), m_spur});
  endfunction

  // Drive one cycle of inputs, take the edge, compare against the model.
  task automatic cycle(input logic [3:0] req, input logic [1:0] busy, input logic [1:0] done);
    req_i = req; dev_busy_i = busy; dev_done_i = done;
    @(posedge clk); #1;
    model_edge(req, busy, done);
    check("model", dut_vec(), model_vec());
  endtask

  task automatic do_reset();
    req_i = '0; dev_busy_i = '0; dev_done_i = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset", dut_vec(), 32'd0);
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] req;  logic [1:0] busy; logic [1:0] done;
    logic [3:0] ack;  logic [1:0] dreq; logic [3:0] cpl;
    logic [3:0] err;  logic [3:0] own;  logic       spur;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [1:0] dn;
    int ng, n;

    tbl[0]  = '{4'b0001, 2'b00, 2'b00, 4'b0001, 2'b01, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[1]  = '{4'b0000, 2'b01, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[2]  = '{4'b0000, 2'b01, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[3]  = '{4'b0000, 2'b01, 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[4]  = '{4'b0000, 2'b01, 2'b01, 4'b0000, 2'b00, 4'b0001, 4'b0000, 4'b0000, 1'b0};
    tbl[5]  = '{4'b0100, 2'b00, 2'b00, 4'b0100, 2'b01, 4'b0000, 4'b0000, 4'b0010, 1'b0};
    tbl[6]  = '{4'b1000, 2'b01, 2'b00, 4'b1000, 2'b10, 4'b0000, 4'b0000, 4'b1110, 1'b0};
    tbl[7]  = '{4'b0000, 2'b11, 2'b11, 4'b0000, 2'b00, 4'b1100, 4'b0000, 4'b0000, 1'b0};
    tbl[8]  = '{4'b0000, 2'b00, 2'b01, 4'b0000, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b1};
    tbl[9]  = '{4'b1001, 2'b00, 2'b00, 4'b0001, 2'b01, 4'b0000, 4'b0000, 4'b0000, 1'b1};
    tbl[10] = '{4'b1000, 2'b01, 2'b00, 4'b1000, 2'b10, 4'b0000, 4'b0000, 4'b1100, 1'b1};
    tbl[11] = '{4'b0000, 2'b11, 2'b10, 4'b0000, 2'b00, 4'b1000, 4'b0000, 4'b0000, 1'b1};
    tbl[12] = '{4'b0000, 2'b00, 2'b01, 4'b0000, 2'b00, 4'b0001, 4'b0000, 4'b0000, 1'b1};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].req, tbl[i].busy, tbl[i].done);
      check($sformatf("vec%0d", i), dut_vec(),
            32'({tbl[i].ack, tbl[i].dreq, tbl[i].cpl, tbl[i].err, tbl[i].own, tbl[i].spur}));
    end

    // Fairness: all requesters held, devices finish right after launch.
    do_reset();
    dn = 2'b00; ng = 0;
    for (int b = 0; b < 60 && ng < 12; b++) begin
      cycle(4'b1111, 2'b00, dn);
      dn = dev_req_o;
      if (ack_o != 4'b0000) begin
        check($sformatf("fair_grant%0d", ng), 32'(ack_o), 32'(4'b0001 << (ng % 4)));
        ng++;
      end
    end
    check("fair_count", 32'(ng), 32'd12);

    // Watchdog: device never completes; busy held afterwards.
    do_reset();
    cycle(4'b0001, 2'b00, 2'b00);
    check("wd_launch", 32'(dev_req_o), 32'(2'b01));
    n = 0;
    while (n < 20 && err_o == 4'b0000) begin
      cycle(4'b0001, 2'b11, 2'b00);
      n++;
    end
    check("wd_latency", 32'(n), 32'd9);
    check("wd_err", 32'(err_o), 32'(4'b0001));
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0001, 2'b11, 2'b00);
      check($sformatf("wd_busy_hold%0d", i), 32'(ack_o), 32'd0);
    end
    cycle(4'b0001, 2'b10, 2'b00);
    check("wd_regrant", 32'({ack_o, dev_req_o}), 32'({4'b0001, 2'b01}));

    // Done on the timeout edge wins; then a spurious done.
    do_reset();
    cycle(4'b0001, 2'b00, 2'b00);
    repeat (8) cycle(4'b0000, 2'b01, 2'b00);
    cycle(4'b0000, 2'b01, 2'b01);
    check("coll_cpl_err", 32'({cpl_o, err_o}), 32'({4'b0001, 4'b0000}));
    cycle(4'b0000, 2'b00, 2'b01);
    check("spur_set", 32'(spur_o), 32'd1);
    cycle(4'b0000, 2'b00, 2'b00);
    check("spur_sticky", 32'(spur_o), 32'd1);

    // Reset mid-job.
    do_reset();
    cycle(4'b0100, 2'b00, 2'b00);
    check("rst_launch", 32'({ack_o, dev_owner_o}), 32'({4'b0100, 4'b0010}));
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_async", dut_vec(), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(4'b0000, 2'b01, 2'b01);
    check("rst_no_cpl", 32'({cpl_o, err_o}), 32'd0);
    check("rst_spur", 32'(spur_o), 32'd1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 999) do_reset();
      cycle(4'($urandom),
            {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)},
            {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout sim_time_limit reached");
    $fatal(1, "simulation time limit");
  end

endmodule
